// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_FIRST = 7;
  localparam int SAMPLE_LAST  = 9;
  localparam int BIT_END      = 15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample slot divider: o_tick is high in the last clock of each DIV-clock slot.
// Held at zero while i_clear is high so the first slot lines up with the start edge.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign o_tick = (r_div_cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, 16x oversampled, 3-sample majority vote per bit.
// rx_done/frame_error pulse 1 cycle after the tick ending stop-bit slot 9; no backpressure.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 115200
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_error
);
  localparam int DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);

  if (DIV < 1) begin : g_div_check
    $error("uart_byte_rx: CLOCK_FREQ too low for BAUD (DIV < 1)");
  end

  logic          r_sync1, r_rx_s, r_rx_d;
  rx_state_e     r_state, w_next;
  logic [SW-1:0] r_slot;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg, r_rx_data;
  logic          r_smp_a, r_smp_b, r_rx_done, r_frame_error;
  logic          w_fall, w_tick, w_clear, w_end9, w_end15, w_bit;
  logic          w_shift, w_done_set, w_ferr_set;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  assign w_fall  = r_rx_d & ~r_rx_s;
  assign w_clear = (r_state == RX_IDLE);
  assign w_end9  = w_tick && (r_slot == SW'(SAMPLE_LAST));
  assign w_end15 = w_tick && (r_slot == SW'(BIT_END));
  // Third vote is the live synchronized sample at the end of slot 9.
  assign w_bit   = maj3(r_smp_a, r_smp_b, r_rx_s);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: begin
        if (w_end9 && w_bit) w_next = RX_IDLE;
        else if (w_end15)    w_next = RX_DATA;
      end
      RX_DATA:  if (w_end15 && (r_bit_idx == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_end9) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_shift    = 1'b0;
    w_done_set = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      RX_DATA: w_shift = w_end9;
      RX_STOP: begin
        w_done_set = w_end9 && w_bit;
        w_ferr_set = w_end9 && !w_bit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1       <= 1'b1;
      r_rx_s        <= 1'b1;
      r_rx_d        <= 1'b1;
      r_slot        <= '0;
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_smp_a       <= 1'b0;
      r_smp_b       <= 1'b0;
      r_rx_data     <= '0;
      r_rx_done     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sync1 <= uart_rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;

      if (w_clear)     r_slot <= '0;
      else if (w_tick) r_slot <= r_slot + SW'(1);

      if (w_tick && (r_slot == SW'(SAMPLE_FIRST)))     r_smp_a <= r_rx_s;
      if (w_tick && (r_slot == SW'(SAMPLE_FIRST + 1))) r_smp_b <= r_rx_s;

      if (r_state == RX_START && w_end15)    r_bit_idx <= '0;
      else if (r_state == RX_DATA && w_end15) r_bit_idx <= r_bit_idx + 3'd1;

      if (w_shift)    r_shreg   <= {w_bit, r_shreg[7:1]};
      if (w_done_set) r_rx_data <= r_shreg;
      r_rx_done     <= w_done_set;
      r_frame_error <= w_ferr_set;
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_done     = r_rx_done;
  assign frame_error = r_frame_error;

endmodule
